// File: rtl/runway_pkg.sv
// rtl/runway_pkg.sv - shared wind code type for the runway-lights blocks
package runway_pkg;

    typedef enum logic [1:0] {
        WIND_CALM = 2'b00,
        WIND_SW0  = 2'b01,
        WIND_SW1  = 2'b10,
        WIND_BAD  = 2'b11
    } wind_t;

endpackage

// File: rtl/switch_debounce.sv
// rtl/switch_debounce.sv - two-flop synchroniser plus candidate/counter debouncer
module switch_debounce #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] value,
    output logic             settle,
    output logic             changing
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [CW-1:0]    cnt;

    // value is the candidate; it follows sync2 one edge late and restarts the count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            value <= '0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 != value) begin
                value <= sync2;
                cnt   <= '0;
            end else if (cnt < CNT_MAX) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign changing = (sync2 != value);
    // true only on the edge where the count reaches saturation
    assign settle   = !changing && (cnt == CNT_LAST);

endmodule

// File: rtl/wind_select_conditioner.sv
// rtl/wind_select_conditioner.sv - debounced wind code, change pulse, illegal flag and step enable
module wind_select_conditioner
    import runway_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STEP_DIV        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] SW,
    output wind_t      wind,
    output logic       wind_change,
    output logic       step,
    output logic       illegal
);

    localparam int PW = $clog2(STEP_DIV);
    localparam logic [PW-1:0] PCNT_LAST = PW'(STEP_DIV - 1);

    logic [1:0]    db_value;
    logic          db_settle;
    logic          db_changing;
    wind_t         cand;
    logic          commit;
    logic [PW-1:0] pcnt;

    switch_debounce #(
        .WIDTH           (2),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk      (clk),
        .reset    (reset),
        .raw      (SW),
        .value    (db_value),
        .settle   (db_settle),
        .changing (db_changing)
    );

    assign cand   = wind_t'(db_value);
    assign commit = db_settle && (cand != WIND_BAD) && (cand != wind);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wind        <= WIND_CALM;
            wind_change <= 1'b0;
            illegal     <= 1'b0;
            step        <= 1'b0;
            pcnt        <= '0;
        end else begin
            wind_change <= commit;
            if (commit) begin
                wind <= cand;
            end

            if (db_settle && cand == WIND_BAD) begin
                illegal <= 1'b1;
            end else if (db_changing && cand == WIND_BAD) begin
                illegal <= 1'b0;
            end

            // a commit re-phases the step cadence to the new wind
            step <= (pcnt == PCNT_LAST) && !commit;
            if (commit || pcnt == PCNT_LAST) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_wind_select_conditioner.sv
// tb/tb_wind_select_conditioner.sv - scoreboard bench for wind_select_conditioner
module tb_wind_select_conditioner;

    localparam int D = 4;
    localparam int P = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] SW = 2'b00;
    logic [1:0] wind;
    logic       wind_change;
    logic       step;
    logic       illegal;

    wind_select_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .STEP_DIV        (P)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .SW          (SW),
        .wind        (wind),
        .wind_change (wind_change),
        .step        (step),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] wind;
        logic       chg;
        logic       stp;
        logic       ill;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   commits_seen = 0;

    // reference model: history of samples, settle = window of D+1 equal synchronised values
    int         k;
    int         anchor;
    logic [1:0] s_arr[0:8191];
    logic [1:0] v_arr[0:8191];
    logic [1:0] m_wind;
    logic       m_ill;

    task automatic model_reset();
        k = 0;
        anchor = 0;
        m_wind = 2'b00;
        m_ill = 1'b0;
        v_arr[0] = 2'b00;
    endtask

    task automatic model_edge(input logic [1:0] sw);
        logic settle;
        logic commit;
        logic stp;
        logic [1:0] cand;
        k++;
        s_arr[k] = sw;
        v_arr[k] = (k >= 3) ? s_arr[k-2] : 2'b00;
        cand = v_arr[k];
        settle = (k >= D);
        if (settle) begin
            for (int i = k - D; i <= k; i++)
                if (v_arr[i] != cand) settle = 1'b0;
            if (k > D && v_arr[k-D-1] == cand) settle = 1'b0;
        end
        commit = settle && cand != 2'b11 && cand != m_wind;
        if (settle && cand == 2'b11) m_ill = 1'b1;
        else if (v_arr[k-1] == 2'b11 && cand != 2'b11) m_ill = 1'b0;
        stp = ((k - anchor) % P == 0) && !commit;
        if (commit) begin
            anchor = k;
            m_wind = cand;
        end
        exp_q.push_back('{wind: m_wind, chg: commit, stp: stp, ill: m_ill});
    endtask

    task automatic check1(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    // one clock: the model sees the SW present at this edge, then SW moves
    task automatic cycle(input logic [1:0] sw_next);
        @(posedge clk);
        model_edge(SW);
        #1 SW = sw_next;
    endtask

    task automatic hold(input logic [1:0] v, input int n);
        for (int i = 0; i < n; i++) cycle(v);
    endtask

    always @(negedge clk) begin
        if (!reset && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check1("wind", int'(wind), int'(e.wind));
            check1("wind_change", int'(wind_change), int'(e.chg));
            check1("step", int'(step), int'(e.stp));
            check1("illegal", int'(illegal), int'(e.ill));
            if (wind_change) commits_seen++;
        end
    end

    task automatic check_zero(input string tag);
        check1({tag, "_wind"}, int'(wind), 0);
        check1({tag, "_wind_change"}, int'(wind_change), 0);
        check1({tag, "_step"}, int'(step), 0);
        check1({tag, "_illegal"}, int'(illegal), 0);
    endtask

    initial begin
        model_reset();
        #23;
        check_zero("reset_hold");
        @(negedge clk);
        #2 reset = 1'b0;

        hold(2'b00, 30);                 // idle cadence
        hold(2'b01, 12);                 // commit 01
        hold(2'b00, 12);                 // back to 00
        hold(2'b01, 3);                  // short bounce
        hold(2'b00, 10);
        hold(2'b11, 20);                 // illegal, wind holds
        hold(2'b10, 14);                 // leave illegal, commit 10
        hold(2'b01, 2);                  // glitch
        hold(2'b10, 20);

        // asynchronous reset mid-debounce, away from any edge
        hold(2'b01, 3);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check_zero("async_reset");
        @(posedge clk);
        #2 check_zero("reset_edge");
        exp_q.delete();
        model_reset();
        @(negedge clk);
        #2 reset = 1'b0;
        hold(2'b01, 14);

        for (int seg = 0; seg < 300; seg++)
            hold(2'($urandom_range(0, 3)), $urandom_range(1, 9));
        hold(2'b00, 12);

        for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d entries left expected 0", exp_q.size());
        end
        total++;
        if (commits_seen < 5) begin
            bad++;
            $display("FAIL commit_activity: got %0d commits expected at least 5", commits_seen);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wind_select_conditioner.md
Name: wind_select_conditioner

Overview:
- Upstream input stage for the runway-lights FSM.
- Takes the raw, asynchronous, bouncy wind switches SW[1:0] and synchronises and debounces them.
- Rejects the illegal code 2'b11 and presents a stable wind code plus a one-cycle change pulse.
- Generates a periodic step enable so the downstream pattern FSM advances at a visible rate, not every clk.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised cycles required before commit; legal range >= 1.
- STEP_DIV, 8: step-enable period in clk cycles; legal range >= 2. Board top overrides both with large values.

Ports:
- clk  in  1  system clock; all state on posedge
- reset  in  1  asynchronous, active-high reset
- SW  in  2  raw wind switches, asynchronous to clk
- wind  out  2  committed wind code (wind_t); never 2'b11
- wind_change  out  1  one-cycle pulse on the cycle wind takes a new value
- step  out  1  one-cycle enable every STEP_DIV cycles
- illegal  out  1  high while the debounced switch code is 2'b11

Behaviour:
- Reset is asynchronous and active-high. While reset is high, or immediately on its assertion mid-operation:
  - sync1, sync2, candidate and wind = 2'b00
  - debounce counter and prescaler = 0
  - wind_change, step, illegal = 0
  - any in-progress debounce is discarded, with no pulse on release
- Synchroniser: two flops, SW -> sync1 -> sync2.
- Debounce, evaluated each edge:
  - If sync2 != candidate: candidate <= sync2 and cnt <= 0.
  - Else if cnt < DEBOUNCE_CYCLES: cnt <= cnt + 1. cnt saturates at DEBOUNCE_CYCLES.
- Commit: occurs on the edge where cnt goes DEBOUNCE_CYCLES-1 -> DEBOUNCE_CYCLES with candidate != 2'b11 and candidate != wind.
  - On that edge: wind <= candidate and wind_change <= 1 for exactly one cycle.
- Latency: SW is stable before edge e0 (first edge that samples it). wind updates at edge e0 + DEBOUNCE_CYCLES + 2, which is 6 edges with the defaults.
- A bounce shorter than the debounce window produces no commit and no pulse.
- A bounce that settles back to the current wind value produces no pulse.
- Illegal code: when candidate == 2'b11 reaches saturation:
  - illegal <= 1; wind holds its previous value; no wind_change.
  - illegal <= 0 on the edge candidate changes away from 2'b11.
- Prescaler: pcnt counts 0..STEP_DIV-1 and wraps.
  - step is registered: step <= (pcnt == STEP_DIV-1) && !commit.
  - On a commit edge, pcnt <= 0. The step phase restarts aligned to the new wind, and a step coinciding with a commit is suppressed.
- First step after reset release occurs at the STEP_DIV-th edge. Thereafter step is high 1 cycle in every STEP_DIV cycles, absent commits.
- Widths:
  - cnt is $clog2(DEBOUNCE_CYCLES+1) bits.
  - pcnt is $clog2(STEP_DIV) bits.
  - No overflow is possible due to saturation and wrap.

Decomposition:
- Package runway_pkg:
  - wind_t enum logic [1:0]: WIND_CALM=2'b00, WIND_SW0=2'b01, WIND_SW1=2'b10, WIND_BAD=2'b11
  - Shared by this block and the pattern FSM.
- Sub-module switch_debounce, parameterised by WIDTH and DEBOUNCE_CYCLES:
  - Contains the synchroniser, candidate and counter.
  - Outputs the debounced value and a stable flag.
- The top block adds the legality check, commit logic and prescaler.

Test Plan:
Defaults throughout: DEBOUNCE_CYCLES=4, STEP_DIV=8.
1. Assert reset, release with SW=00 -> wind=00, illegal=0, wind_change=0; step pulses one cycle at edges 8, 16, 24 after release.
2. SW 00->01 held -> wind=01 at the 6th edge after change, with wind_change=1 that cycle only. The step suppressed if coincident, and next step 8 edges after commit.
3. SW=01 for 3 cycles then back to 00 -> wind stays 00, wind_change never asserts.
4. SW=11 held 20 cycles -> illegal=1 from edge 6, wind holds prior value, no pulse. Then SW=10 -> illegal=0 after 3 edges, wind=10 at the 6th edge with one pulse.
5. Assert reset asynchronously mid-debounce, between edges (SW change in progress) -> all outputs 0 immediately. After release with SW still 01, the full 6-edge latency elapses before commit.
6. Hold wind=10, then glitch SW to 01 for 2 cycles and back to 10 -> no wind_change; step cadence is undisturbed.
